// File: rtl/gauss3x3_stream.sv
// gauss3x3_stream
//   Streaming 3x3 Gaussian smoothing stage, kernel [1 2 1; 2 4 2; 1 2 1]/16,
//   for a raster-order 8-bit grayscale stream of WIDTH x HEIGHT pixels.
//   Two line buffers hold the previous two rows; one smoothed pixel is
//   produced for every interior position, two cycles after the input edge
//   that completes its window.
//
//   Build option: define GAUSS_ROUND_EN for round-half-up ((sum+8)>>4);
//   the default build truncates (sum>>4). Latency is identical in both builds.
//
// Ports
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   in_valid   in   in_pixel carries the next raster pixel
//   in_pixel   in   8-bit input sample
//   out_valid  out  out_pixel/out_x/out_y valid
//   out_pixel  out  8-bit smoothed sample
//   out_x      out  column of window centre
//   out_y      out  row of window centre
//   frame_done out  pulse with the last output of a frame (centre WIDTH-2, HEIGHT-2)
module gauss3x3_stream #(
  parameter  int WIDTH  = 128,
  parameter  int HEIGHT = 128,
  localparam int XW     = $clog2(WIDTH),
  localparam int YW     = $clog2(HEIGHT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [7:0]    in_pixel,
  output logic          out_valid,
  output logic [7:0]    out_pixel,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic          frame_done
);

  // reset wins over a simultaneous pixel: the pixel is dropped entirely
  logic w_acc;
  assign w_acc = in_valid & ~rst;

  // ---------------------------------------------------------------------------
  // Input position counters
  // ---------------------------------------------------------------------------
  logic [XW-1:0] r_col;
  logic [YW-1:0] r_row;
  logic          w_col_last;
  logic          w_row_last;

  assign w_col_last = (r_col == XW'(WIDTH - 1));
  assign w_row_last = (r_row == YW'(HEIGHT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (in_valid) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Line buffers: lb0 holds row-1, lb1 holds row-2 (read-before-write)
  // ---------------------------------------------------------------------------
  logic [7:0] r_lb0 [WIDTH];
  logic [7:0] r_lb1 [WIDTH];
  logic [7:0] w_lb0_rd;
  logic [7:0] w_lb1_rd;

  assign w_lb0_rd = r_lb0[r_col];
  assign w_lb1_rd = r_lb1[r_col];

  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_lb0[r_col] <= in_pixel;
      r_lb1[r_col] <= w_lb0_rd;
    end
  end

  // ---------------------------------------------------------------------------
  // 3x3 window, r_win[row][col]; col 2 is the newest column, row 0 the oldest row.
  // Contents are not reset: the completion gating below keeps stale taps away
  // from the output.
  // ---------------------------------------------------------------------------
  logic [7:0] r_win [3][3];

  always_ff @(posedge clk) begin
    if (w_acc) begin
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= r_win[r][1];
        r_win[r][1] <= r_win[r][2];
      end
      r_win[0][2] <= w_lb1_rd;
      r_win[1][2] <= w_lb0_rd;
      r_win[2][2] <= in_pixel;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 0 tag: the window becomes complete on this edge
  // ---------------------------------------------------------------------------
  logic          w_win_done;
  logic          r_v0;
  logic          r_fd0;
  logic [XW-1:0] r_x0;
  logic [YW-1:0] r_y0;

  assign w_win_done = w_acc && (r_col >= XW'(2)) && (r_row >= YW'(2));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v0  <= 1'b0;
      r_fd0 <= 1'b0;
      r_x0  <= '0;
      r_y0  <= '0;
    end else begin
      r_v0 <= w_win_done;
      if (w_win_done) begin
        r_fd0 <= w_col_last & w_row_last;
        r_x0  <= r_col - 1'b1;
        r_y0  <= r_row - 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: row-wise [1 2 1] partial sums (max 1020, 10 bits)
  // ---------------------------------------------------------------------------
  logic [9:0]    r_rs [3];
  logic          r_v1;
  logic          r_fd1;
  logic [XW-1:0] r_x1;
  logic [YW-1:0] r_y1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1 <= 1'b0;
    end else begin
      r_v1 <= r_v0;
    end
  end

  always_ff @(posedge clk) begin
    if (r_v0) begin
      for (int r = 0; r < 3; r++) begin
        r_rs[r] <= 10'(r_win[r][0]) + (10'(r_win[r][1]) << 1) + 10'(r_win[r][2]);
      end
      r_fd1 <= r_fd0;
      r_x1  <= r_x0;
      r_y1  <= r_y0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: column combine (max 4080, 12 bits) and scale by 1/16
  // ---------------------------------------------------------------------------
  logic [11:0] w_sum;
  logic [11:0] w_res;
  logic [7:0]  w_pix;

  assign w_sum = 12'(r_rs[0]) + (12'(r_rs[1]) << 1) + 12'(r_rs[2]);
`ifdef GAUSS_ROUND_EN
  assign w_res = w_sum + 12'd8;   // cannot overflow: 4080 + 8 < 4096
`else
  assign w_res = w_sum;
`endif
  assign w_pix = 8'(w_res >> 4);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_pixel  <= '0;
      out_x      <= '0;
      out_y      <= '0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= r_v1;
      frame_done <= r_v1 & r_fd1;
      if (r_v1) begin
        out_pixel <= w_pix;
        out_x     <= r_x1;
        out_y     <= r_y1;
      end
    end
  end

endmodule

// File: tb/tb_gauss3x3_stream.sv
module tb_gauss3x3_stream;

  localparam int W = 128;
  localparam int H = 128;
  localparam int NOUT = (W - 2) * (H - 2);

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_pixel;
  logic       out_valid;
  logic [7:0] out_pixel;
  logic [6:0] out_x;
  logic [6:0] out_y;
  logic       frame_done;

  gauss3x3_stream #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_pixel   (in_pixel),
    .out_valid  (out_valid),
    .out_pixel  (out_pixel),
    .out_x      (out_x),
    .out_y      (out_y),
    .frame_done (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int chk = 0;
  int err = 0;

  logic [7:0] img    [H][W];
  logic [7:0] outimg [H][W];

  typedef struct {
    int ecyc;
    int x;
    int y;
    int pix;
    bit fd;
  } exp_t;
  exp_t q[$];

  int tb_col, tb_row, in_idx, e258;
  int mon_cnt, mon_bad, mon_fd;
  int mon_fd_cnt[4];
  bit mon_seen;
  int first_x, first_y, first_pix, first_cyc, last_x, last_y;

  // reference convolution taken straight from the stored image
  function automatic int gexp(int x, int y);
    int s;
    s = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        s += int'(img[y+dy][x+dx]) * ((dx == 0) ? 2 : 1) * ((dy == 0) ? 2 : 1);
`ifdef GAUSS_ROUND_EN
    return (s + 8) >> 4;
`else
    return s >> 4;
`endif
  endfunction

  // output monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].ecyc < cyc) begin
        mon_bad++;
        void'(q.pop_front());
      end
      if (out_valid === 1'b1) begin
        mon_cnt++;
        if (q.size() == 0) begin
          mon_bad++;
        end else begin
          e = q.pop_front();
          if (int'(out_x) != e.x || int'(out_y) != e.y || int'(out_pixel) != e.pix ||
              cyc != e.ecyc || frame_done !== e.fd)
            mon_bad++;
        end
        if (frame_done === 1'b1) begin
          if (mon_fd < 4) mon_fd_cnt[mon_fd] = mon_cnt;
          mon_fd++;
        end
        outimg[out_y][out_x] = out_pixel;
        if (!mon_seen) begin
          mon_seen  = 1'b1;
          first_x   = int'(out_x);
          first_y   = int'(out_y);
          first_pix = int'(out_pixel);
          first_cyc = cyc;
        end
        last_x = int'(out_x);
        last_y = int'(out_y);
      end else if (out_valid !== 1'b0 || frame_done !== 1'b0) begin
        mon_bad++;
      end
    end
  end

  task automatic mon_clear();
    mon_cnt = 0; mon_bad = 0; mon_fd = 0; mon_seen = 1'b0;
    for (int i = 0; i < 4; i++) mon_fd_cnt[i] = 0;
    first_x = -1; first_y = -1; first_pix = -1; first_cyc = -1;
    last_x = -1; last_y = -1;
    in_idx = 0; e258 = -1;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        outimg[y][x] = 8'd222;
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        img[y][x] = v;
  endtask

  task automatic drive_next();
    exp_t e;
    @(negedge clk);
    #1;
    in_valid = 1'b1;
    in_pixel = img[tb_row][tb_col];
    if (in_idx == 2 * W + 2) e258 = cyc + 1;
    in_idx++;
    if (tb_col >= 2 && tb_row >= 2) begin
      e.ecyc = cyc + 3;
      e.x    = tb_col - 1;
      e.y    = tb_row - 1;
      e.pix  = gexp(e.x, e.y);
      e.fd   = (tb_col == W - 1) && (tb_row == H - 1);
      q.push_back(e);
    end
    if (tb_col == W - 1) begin
      tb_col = 0;
      tb_row = (tb_row == H - 1) ? 0 : tb_row + 1;
    end else begin
      tb_col++;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drive_frame(input bit gaps);
    repeat (W * H) begin
      if (gaps) while ($urandom_range(0, 7) == 0) idle();
      drive_next();
    end
  endtask

  // leaves rst high at a falling edge after n reset edges; a pixel is offered
  // alongside reset and must be dropped
  task automatic reset_begin(input int n);
    @(negedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b1;
    in_pixel = 8'd200;
    q.delete();
    tb_col = 0;
    tb_row = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_end();
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_pixel = 8'h55;
    tb_col = 0; tb_row = 0;
    repeat (3) @(negedge clk);
    chk++; if (out_valid !== 1'b0) begin err++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    chk++; if (out_pixel !== 8'd0) begin err++; $display("FAIL rst_out_pixel got %0d want 0", out_pixel); end
    chk++; if (out_x !== 7'd0) begin err++; $display("FAIL rst_out_x got %0d want 0", out_x); end
    chk++; if (out_y !== 7'd0) begin err++; $display("FAIL rst_out_y got %0d want 0", out_y); end
    chk++; if (frame_done !== 1'b0) begin err++; $display("FAIL rst_frame_done got %b want 0", frame_done); end
    reset_end();
  endtask

  task automatic test_const_back_to_back();
    fill_const(8'd100);
    mon_clear();
    drive_frame(1'b0);
    fill_const(8'd200);
    drive_frame(1'b0);
    repeat (4) idle();
    chk++; if (mon_bad !== 0) begin err++; $display("FAIL b2b_scoreboard got %0d bad outputs want 0", mon_bad); end
    chk++; if (mon_fd !== 2) begin err++; $display("FAIL b2b_frame_done got %0d pulses want 2", mon_fd); end
    chk++; if (mon_fd_cnt[0] !== NOUT) begin err++; $display("FAIL b2b_count_f1 got %0d want %0d", mon_fd_cnt[0], NOUT); end
    chk++; if (mon_fd_cnt[1] - mon_fd_cnt[0] !== NOUT) begin err++; $display("FAIL b2b_count_f2 got %0d want %0d", mon_fd_cnt[1] - mon_fd_cnt[0], NOUT); end
    chk++; if (mon_cnt !== 2 * NOUT) begin err++; $display("FAIL b2b_count_total got %0d want %0d", mon_cnt, 2 * NOUT); end
    chk++; if (first_cyc !== e258 + 2) begin err++; $display("FAIL const_first_latency got cycle %0d want %0d", first_cyc, e258 + 2); end
    chk++; if (first_x !== 1 || first_y !== 1) begin err++; $display("FAIL const_first_xy got (%0d,%0d) want (1,1)", first_x, first_y); end
    chk++; if (first_pix !== 100) begin err++; $display("FAIL const_first_pix got %0d want 100", first_pix); end
    chk++; if (last_x !== 126 || last_y !== 126) begin err++; $display("FAIL b2b_last_xy got (%0d,%0d) want (126,126)", last_x, last_y); end
    chk++; if (outimg[1][1] !== 8'd200) begin err++; $display("FAIL b2b_f2_first_pix got %0d want 200", outimg[1][1]); end
    chk++; if (outimg[126][126] !== 8'd200) begin err++; $display("FAIL b2b_f2_last_pix got %0d want 200", outimg[126][126]); end
    chk++; if (q.size() !== 0) begin err++; $display("FAIL b2b_pending got %0d want 0", q.size()); end
  endtask

  task automatic test_impulse();
    int c_exp, e_exp, k_exp;
`ifdef GAUSS_ROUND_EN
    c_exp = 64; e_exp = 32; k_exp = 16;
`else
    c_exp = 63; e_exp = 31; k_exp = 15;
`endif
    reset_begin(1);
    reset_end();
    fill_const(8'd0);
    img[64][64] = 8'd255;
    mon_clear();
    repeat (70 * W) drive_next();
    repeat (4) idle();
    chk++; if (mon_bad !== 0) begin err++; $display("FAIL imp_scoreboard got %0d bad outputs want 0", mon_bad); end
    chk++; if (mon_cnt !== 68 * 126) begin err++; $display("FAIL imp_count got %0d want %0d", mon_cnt, 68 * 126); end
    chk++; if (int'(outimg[64][64]) !== c_exp) begin err++; $display("FAIL imp_centre got %0d want %0d", outimg[64][64], c_exp); end
    chk++; if (int'(outimg[63][64]) !== e_exp) begin err++; $display("FAIL imp_edge_n got %0d want %0d", outimg[63][64], e_exp); end
    chk++; if (int'(outimg[64][65]) !== e_exp) begin err++; $display("FAIL imp_edge_e got %0d want %0d", outimg[64][65], e_exp); end
    chk++; if (int'(outimg[63][63]) !== k_exp) begin err++; $display("FAIL imp_corner_nw got %0d want %0d", outimg[63][63], k_exp); end
    chk++; if (int'(outimg[65][65]) !== k_exp) begin err++; $display("FAIL imp_corner_se got %0d want %0d", outimg[65][65], k_exp); end
    chk++; if (outimg[62][64] !== 8'd0) begin err++; $display("FAIL imp_outside_n got %0d want 0", outimg[62][64]); end
    chk++; if (outimg[64][66] !== 8'd0) begin err++; $display("FAIL imp_outside_e got %0d want 0", outimg[64][66]); end
  endtask

  task automatic test_ramp_gaps();
    reset_begin(1);
    reset_end();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        img[y][x] = 8'(x);
    mon_clear();
    drive_frame(1'b1);
    repeat (4) idle();
    chk++; if (mon_bad !== 0) begin err++; $display("FAIL ramp_scoreboard got %0d bad outputs want 0", mon_bad); end
    chk++; if (mon_cnt !== NOUT) begin err++; $display("FAIL ramp_count got %0d want %0d", mon_cnt, NOUT); end
    chk++; if (mon_fd !== 1) begin err++; $display("FAIL ramp_frame_done got %0d want 1", mon_fd); end
    chk++; if (first_x !== 1 || first_y !== 1) begin err++; $display("FAIL ramp_first_xy got (%0d,%0d) want (1,1)", first_x, first_y); end
    chk++; if (last_x !== 126 || last_y !== 126) begin err++; $display("FAIL ramp_last_xy got (%0d,%0d) want (126,126)", last_x, last_y); end
    chk++; if (outimg[1][1] !== 8'd1) begin err++; $display("FAIL ramp_pix_1_1 got %0d want 1", outimg[1][1]); end
    chk++; if (outimg[70][126] !== 8'd126) begin err++; $display("FAIL ramp_pix_126_70 got %0d want 126", outimg[70][126]); end
    chk++; if (outimg[126][63] !== 8'd63) begin err++; $display("FAIL ramp_pix_63_126 got %0d want 63", outimg[126][63]); end
    chk++; if (q.size() !== 0) begin err++; $display("FAIL ramp_pending got %0d want 0", q.size()); end
  endtask

  task automatic test_reset_midframe();
    reset_begin(1);
    reset_end();
    fill_const(8'd33);
    mon_clear();
    repeat (5000) drive_next();
    chk++; if (mon_bad !== 0) begin err++; $display("FAIL mid_pre_scoreboard got %0d bad outputs want 0", mon_bad); end
    reset_begin(1);
    chk++; if (out_valid !== 1'b0) begin err++; $display("FAIL mid_rst_out_valid got %b want 0", out_valid); end
    chk++; if (out_pixel !== 8'd0) begin err++; $display("FAIL mid_rst_out_pixel got %0d want 0", out_pixel); end
    chk++; if (out_x !== 7'd0 || out_y !== 7'd0) begin err++; $display("FAIL mid_rst_out_xy got (%0d,%0d) want (0,0)", out_x, out_y); end
    chk++; if (frame_done !== 1'b0) begin err++; $display("FAIL mid_rst_frame_done got %b want 0", frame_done); end
    reset_end();
    fill_const(8'd77);
    mon_clear();
    drive_frame(1'b0);
    repeat (4) idle();
    chk++; if (mon_bad !== 0) begin err++; $display("FAIL mid_scoreboard got %0d bad outputs want 0", mon_bad); end
    chk++; if (mon_cnt !== NOUT) begin err++; $display("FAIL mid_count got %0d want %0d", mon_cnt, NOUT); end
    chk++; if (first_x !== 1 || first_y !== 1) begin err++; $display("FAIL mid_first_xy got (%0d,%0d) want (1,1)", first_x, first_y); end
    chk++; if (first_pix !== 77) begin err++; $display("FAIL mid_first_pix got %0d want 77", first_pix); end
    chk++; if (first_cyc !== e258 + 2) begin err++; $display("FAIL mid_first_latency got cycle %0d want %0d", first_cyc, e258 + 2); end
    chk++; if (mon_fd !== 1) begin err++; $display("FAIL mid_frame_done got %0d want 1", mon_fd); end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_pixel = 8'd0;
    mon_clear();
    test_reset();
    test_const_back_to_back();
    test_impulse();
    test_ramp_gaps();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
